// File: rtl/seq_booth_mul_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth sequential multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_e;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned CNT_W = $clog2(DEFAULT_WIDTH / 2 + 2);

  // Two guard bits on the multiplier give WIDTH/2 + 1 radix-4 digits.
  function automatic int unsigned iter_count(input int unsigned width);
    return width / 2 + 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width / 2 + 2);
  endfunction

endpackage

// File: rtl/seq_booth_mul_if.sv
// Start/Busy/Done bundle between the requester and the multiplier.
interface seq_booth_mul_if #(parameter int WIDTH = 8);
  // Handshake: start is honoured only on an edge where busy is low; operands and
  // sign_mode are captured on that edge. done pulses for exactly one cycle when
  // product becomes valid; product then holds until the next accepted start.
  logic                 start;
  logic                 sign_mode;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;
  logic                 done;

  modport master (
    output start, sign_mode, multiplicand, multiplier,
    input  product, busy, done
  );

  modport slave (
    input  start, sign_mode, multiplicand, multiplier,
    output product, busy, done
  );
endinterface

// File: rtl/seq_booth_mul_booth_encoder.sv
// Radix-4 Booth recoder: maps a multiplier bit triple to a signed digit.
module booth_encoder
  import mul_pkg::*;
(
  input  logic [2:0]   triple_i,
  output booth_digit_e digit_o
);

  always_comb begin
    digit_o = ZERO;
    unique case (triple_i)
      3'b000, 3'b111: digit_o = ZERO;
      3'b001, 3'b010: digit_o = POS1;
      3'b011:         digit_o = POS2;
      3'b100:         digit_o = NEG2;
      3'b101, 3'b110: digit_o = NEG1;
      default:        digit_o = ZERO;
    endcase
  end

endmodule

// File: rtl/seq_booth_mul.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation.
module seq_booth_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  seq_booth_mul_if.slave   bus,
  output state_e           state_o
);

  localparam int EW    = WIDTH + 2;
  localparam int HW    = WIDTH + 3;
  localparam int PW    = 2 * WIDTH;
  localparam int N     = iter_count(WIDTH);
  localparam int CW    = cnt_width(WIDTH);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("seq_booth_mul: WIDTH must be even and >= 4");
  end

  state_e          state_q, state_d;
  logic [HW-1:0]   hi_q, hi_d;
  logic [EW-1:0]   lo_q, lo_d;
  logic            qm1_q, qm1_d;
  logic [HW-1:0]   m_q, m_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   product_q, product_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  booth_digit_e    digit;
  logic [HW-1:0]   multiple;
  logic [HW-1:0]   sum;
  logic [HW-1:0]   hi_sh;
  logic [EW-1:0]   lo_sh;

  booth_encoder u_enc (
    .triple_i ({lo_q[1:0], qm1_q}),
    .digit_o  (digit)
  );

  always_comb begin
    multiple = '0;
    unique case (digit)
      ZERO:    multiple = '0;
      POS1:    multiple = m_q;
      POS2:    multiple = {m_q[HW-2:0], 1'b0};
      NEG1:    multiple = -m_q;
      NEG2:    multiple = -{m_q[HW-2:0], 1'b0};
      default: multiple = '0;
    endcase
    sum   = hi_q + multiple;
    // The multiplier bits are consumed from lo while result bits shift in above them.
    hi_sh = {{2{sum[HW-1]}}, sum[HW-1:2]};
    lo_sh = {sum[1:0], lo_q[EW-1:2]};
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          m_d     = {{3{bus.sign_mode & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
          lo_d    = {{2{bus.sign_mode & bus.multiplier[WIDTH-1]}}, bus.multiplier};
          hi_d    = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        hi_d  = hi_sh;
        lo_d  = lo_sh;
        qm1_d = lo_q[1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          product_d = {hi_sh[WIDTH-3:0], lo_sh};
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign state_o     = state_q;

endmodule
